// File: rtl/host_cmd_pkg.sv
// Shared definitions for the host-side UART command initiator: frame codes,
// command encodings, FSM states and per-command frame/response lengths.
package host_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_t;

  localparam logic [7:0] CODE_RF_WR   = 8'hAA;
  localparam logic [7:0] CODE_RF_RD   = 8'hBB;
  localparam logic [7:0] CODE_ALU_OP  = 8'hCC;
  localparam logic [7:0] CODE_ALU_NOP = 8'hDD;

  function automatic logic [7:0] frame_code(input cmd_t t);
    logic [7:0] c;
    c = CODE_RF_WR;
    case (t)
      CMD_RF_WR:   c = CODE_RF_WR;
      CMD_RF_RD:   c = CODE_RF_RD;
      CMD_ALU_OP:  c = CODE_ALU_OP;
      CMD_ALU_NOP: c = CODE_ALU_NOP;
      default:     c = CODE_RF_WR;
    endcase
    return c;
  endfunction

  // Frame length N (code byte included).
  function automatic logic [2:0] frame_len(input cmd_t t);
    logic [2:0] n;
    n = 3'd2;
    case (t)
      CMD_RF_WR:   n = 3'd3;
      CMD_RF_RD:   n = 3'd2;
      CMD_ALU_OP:  n = 3'd4;
      CMD_ALU_NOP: n = 3'd2;
      default:     n = 3'd2;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_t t);
    logic [1:0] r;
    r = 2'd0;
    case (t)
      CMD_RF_WR:   r = 2'd0;
      CMD_RF_RD:   r = 2'd1;
      CMD_ALU_OP:  r = 2'd2;
      CMD_ALU_NOP: r = 2'd2;
      default:     r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/host_cmd_master_rsp_timer.sv
// Clearable saturating idle counter for the response wait; tc flags the
// increment that lands on TIMEOUT, so the owner can register its pulse.
module rsp_timer #(
  parameter int TIMEOUT = 1023,
  localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = inc && !clr && (cnt_q == PRE);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != TERM)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/host_cmd_master.sv
// Serializes one command into UART bytes, then gathers up to two response bytes
// or times out; first byte one cycle after accept, bytes held until tx_ready.
module host_cmd_master
  import host_cmd_pkg::*;
#(
  parameter int width   = 8,
  parameter int depth   = 16,
  parameter int TIMEOUT = 1023,
  localparam int ADDR_W = $clog2(depth)
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [width-1:0]   cmd_a,
  input  logic [width-1:0]   cmd_b,
  input  logic [3:0]         cmd_fun,
  output logic [width-1:0]   tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [width-1:0]   rx_data,
  input  logic               rx_valid,
  output logic               rsp_valid,
  output logic [2*width-1:0] rsp_data,
  output logic               rsp_timeout,
  output logic               busy
);

  state_t             state_q, state_d;
  cmd_t               type_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [width-1:0]   a_q, b_q;
  logic [3:0]         fun_q;
  logic [1:0]         idx_q, idx_d, nxt_idx;
  logic               rx_cnt_q, rx_cnt_d;
  logic [width-1:0]   tx_data_d, next_byte;
  logic               tx_valid_d, rsp_valid_d, rsp_timeout_d;
  logic [2*width-1:0] rsp_data_d;
  logic               accept, last_byte, last_rsp;
  logic               tmr_clr, tmr_inc, tmr_tc;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign nxt_idx   = idx_q + 2'd1;
  assign last_byte = ({1'b0, idx_q} + 3'd1) == frame_len(type_q);
  assign last_rsp  = ({1'b0, rx_cnt_q} + 2'd1) == rsp_len(type_q);

  assign tmr_inc = (state_q == ST_WAIT_RSP);
  assign tmr_clr = (state_q != ST_WAIT_RSP) || rx_valid;

  rsp_timer #(.TIMEOUT(TIMEOUT)) u_rsp_timer (
    .CLK  (CLK),
    .Reset(Reset),
    .clr  (tmr_clr),
    .inc  (tmr_inc),
    .tc   (tmr_tc)
  );

  // Payload byte that follows the one currently on tx_data.
  always_comb begin
    next_byte = '0;
    case (nxt_idx)
      2'd1: begin
        case (type_q)
          CMD_RF_WR, CMD_RF_RD: next_byte = width'(addr_q);
          CMD_ALU_OP:           next_byte = a_q;
          CMD_ALU_NOP:          next_byte = width'(fun_q);
          default:              next_byte = '0;
        endcase
      end
      2'd2:    next_byte = (type_q == CMD_RF_WR) ? a_q : b_q;
      2'd3:    next_byte = width'(fun_q);
      default: next_byte = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rx_cnt_d      = rx_cnt_q;
    tx_data_d     = tx_data;
    tx_valid_d    = tx_valid;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_data_d    = rsp_data;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d    = ST_SEND;
          idx_d      = 2'd0;
          rx_cnt_d   = 1'b0;
          tx_data_d  = width'(frame_code(cmd_t'(cmd_type)));
          tx_valid_d = 1'b1;
          rsp_data_d = '0;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (last_byte) begin
            tx_valid_d = 1'b0;
            if (rsp_len(type_q) == 2'd0) begin
              state_d     = ST_IDLE;
              rsp_valid_d = 1'b1;
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end else begin
            idx_d     = nxt_idx;
            tx_data_d = next_byte;
          end
        end
      end
      ST_WAIT_RSP: begin
        // A byte arriving on the terminal cycle wins over the timeout.
        if (rx_valid) begin
          if (rx_cnt_q) rsp_data_d[2*width-1:width] = rx_data;
          else          rsp_data_d[width-1:0]       = rx_data;
          if (last_rsp) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
          end else begin
            rx_cnt_d = 1'b1;
          end
        end else if (tmr_tc) begin
          state_d       = ST_IDLE;
          rsp_timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      type_q      <= CMD_RF_WR;
      addr_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      idx_q       <= '0;
      rx_cnt_q    <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_data     <= tx_data_d;
      tx_valid    <= tx_valid_d;
      rsp_valid   <= rsp_valid_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_data    <= rsp_data_d;
      if (accept) begin
        type_q <= cmd_t'(cmd_type);
        addr_q <= cmd_addr;
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        fun_q  <= cmd_fun;
      end
    end
  end

endmodule
